// File: rtl/dmem_responder_if.sv
// Load/store request bus between the pipeline M stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();

    logic              req_read;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              stall;
    logic              ack;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req_read,
        output req_write,
        output req_addr,
        output req_wdata,
        input  stall,
        input  ack,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req_read,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output stall,
        output ack,
        output rvalid,
        output rdata,
        output err
    );

endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, stalls the
// pipeline for LATENCY+1 cycles, then completes with a one-cycle ack/rvalid pulse.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_e              state_q,  state_d;
    logic [3:0]          cnt_q,    cnt_d;
    logic                op_wr_q,  op_wr_d;
    logic                op_rd_q,  op_rd_d;
    logic                op_err_q, op_err_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic                ack_q,    ack_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q,    err_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                req_s;
    logic                last_busy_s;
    logic                commit_s;
    logic                stall_s;

    // Request detect, final BUSY cycle, write commit enable and upstream stall.
    always_comb begin
        req_s       = bus.req_read | bus.req_write;
        last_busy_s = (state_q == ST_BUSY) && (cnt_q == 4'd0);
        // A reset landing on the BUSY->DONE edge must leave memory untouched.
        commit_s    = last_busy_s && op_wr_q && !rst;
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = ((state_q == ST_IDLE) && req_s) || (state_q == ST_BUSY);
        end
    end

    // Next-state, latched request and registered response pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        op_rd_d  = op_rd_q;
        op_err_d = op_err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d  = ST_BUSY;
                    cnt_d    = CNT_INIT;
                    // Write wins on a read+write collision; the read is dropped.
                    op_wr_d  = bus.req_write;
                    op_rd_d  = bus.req_read & ~bus.req_write;
                    op_err_d = bus.req_read & bus.req_write;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_BUSY;
                end else begin
                    state_d  = ST_DONE;
                    ack_d    = 1'b1;
                    rvalid_d = op_rd_q;
                    err_d    = op_err_q;
                    if (op_rd_q) begin
                        rdata_d = mem[addr_q];
                    end else begin
                        rdata_d = rdata_q;
                    end
                end
            end
            ST_DONE: begin
                // Request still visible here belongs to the completing instruction.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            op_wr_q  <= 1'b0;
            op_rd_q  <= 1'b0;
            op_err_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            op_rd_q  <= op_rd_d;
            op_err_q <= op_err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.stall  = stall_s;
    assign bus.ack    = ack_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;

endmodule
